key_slice_reader: RTL and testbench
===================================

// Module: key_slice_reader
// PURPOSE
//   Read-back path for the key store: streams stored key material out in 32-bit slices,
//   the reverse of the slice-wise write path (keyInput/writeEnable/sliceSelector).
//   Accepts a read command (key, first slice, slice count), snapshots the selected key
//   and emits slices on a valid/ready stream toward the host bus or a crypto core.
//   Slice numbering matches the write path: slice n = key bits [32n+31:32n].
// PARAMETERS
//   SLICE_W     32    width of one slice / dataOut
//   MAX_SLICES  32    slices in the widest key (1024 / SLICE_W)
// PORTS
//   clock        in   1     system clock, all state on rising edge
//   resetN       in   1     asynchronous active-low reset
//   privateKey   in   128   key store output, 4 slices
//   q            in   160   key store output, 5 slices
//   p            in   1024  key store output, 32 slices
//   g            in   1024  key store output, 32 slices
//   y            in   1024  key store output, 32 slices
//   cmdValid     in   1     read command present
//   cmdReady     out  1     block idle, command can be accepted
//   cmdKey       in   3     0=privateKey 1=q 2=p 3=g 4=y, 5-7 illegal
//   cmdFirst     in   5     first slice index
//   cmdCount     in   6     number of slices, legal 1..32
//   abort        in   1     cancel current stream
//   dataOut      out  32    current slice
//   dataValid    out  1     dataOut/dataSlice/dataLast valid
//   dataReady    in   1     consumer accepts slice
//   dataSlice    out  5     slice index of dataOut
//   dataLast     out  1     final slice of command
//   cmdError     out  1     one-cycle pulse: command rejected
// BEHAVIOUR
//   - Reset (resetN=0, async): state IDLE, dataOut=0, dataValid=0, dataSlice=0, dataLast=0,
//     cmdError=0, shadow key=0, counters=0. cmdReady = (state==IDLE), so 1 in reset.
//   - FSM IDLE/STREAM. Accept = cmdValid & cmdReady at rising edge.
//   - Legality: cmdKey<=4, cmdCount!=0, cmdFirst+cmdCount <= N(key); N = 4,5,32,32,32.
//     Illegal accept: stay IDLE, cmdError=1 for exactly the next cycle, no data emitted.
//   - Legal accept: shadow <= selected key zero-extended to 1024 b; idx <= cmdFirst;
//     rem <= cmdCount; -> STREAM. First dataValid=1 the cycle after accept (latency 1).
//   - Snapshot: key-store writes after accept do not affect slices of that command.
//   - STREAM: dataOut = shadow[idx*32 +: 32], dataSlice = idx, dataLast = (rem==1).
//     Outputs held stable while dataValid & !dataReady.
//   - Slice handshake (dataValid & dataReady): if rem==1 -> IDLE, dataValid=0 next cycle,
//     cmdReady=1 next cycle; else idx+1, rem-1, dataValid stays 1 (no bubble, 1 slice/clk).
//   - idx never wraps: legality check guarantees idx <= 31 throughout.
//   - abort=1 in STREAM: -> IDLE next cycle, dataValid/dataLast=0, pending slice dropped
//     even if dataReady same cycle. abort in IDLE ignored; abort wins over cmdValid.
//   - cmdReady=0 throughout STREAM; commands presented then are held off, not lost.
//   - Reset mid-stream: outputs return to reset values immediately; no partial resume.
// TESTING
//   1 p loaded with slice0=C5F4B81A, slice1=00000001; cmd key=2 first=0 count=2, dataReady=1
//     -> dataValid 1 cycle after accept, C5F4B81A/slice0, then 00000001/slice1 dataLast=1.
//   2 q, cmd key=1 first=3 count=2 -> slices 3,4 = q[127:96], q[159:128]; count=3 -> cmdError
//     pulse 1 cycle, dataValid stays 0, cmdReady stays 1.
//   3 cmd key=4 count=32, dataReady toggling 1/0 -> 32 slices idx 0..31 in order, outputs
//     stable during stalls, dataLast only on idx 31; key=5 or count=0 -> cmdError.
//   4 cmd key=0 count=4, overwrite privateKey 2 cycles after accept -> stream returns old
//     value; next command returns new value.
//   5 abort at 3rd slice of 8 with dataReady=1 -> dataValid=0 next cycle, cmdReady=1,
//     new command accepted and streams from its cmdFirst.
//   6 resetN pulsed low mid-stream (not clock-aligned) -> all outputs at reset values
//     immediately, cmdReady=1, no slices after release until a new command.

Source files
------------

// File: rtl/key_slice_reader.sv
// Key store read-back path: snapshots one key on command and streams it out
// as SLICE_W-bit slices over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for a read command, cmdReady high
// STREAM | presenting slices from the shadow copy until last slice or abort
module key_slice_reader #(
    parameter int SLICE_W    = 32,
    parameter int MAX_SLICES = 32
) (
    input  logic                          clock,
    input  logic                          resetN,
    input  logic [4*SLICE_W-1:0]          privateKey,
    input  logic [5*SLICE_W-1:0]          q,
    input  logic [MAX_SLICES*SLICE_W-1:0] p,
    input  logic [MAX_SLICES*SLICE_W-1:0] g,
    input  logic [MAX_SLICES*SLICE_W-1:0] y,
    input  logic                          cmdValid,
    output logic                          cmdReady,
    input  logic [2:0]                    cmdKey,
    input  logic [$clog2(MAX_SLICES)-1:0] cmdFirst,
    input  logic [$clog2(MAX_SLICES):0]   cmdCount,
    input  logic                          abort,
    output logic [SLICE_W-1:0]            dataOut,
    output logic                          dataValid,
    input  logic                          dataReady,
    output logic [$clog2(MAX_SLICES)-1:0] dataSlice,
    output logic                          dataLast,
    output logic                          cmdError
);

    localparam int KEY_W  = SLICE_W * MAX_SLICES;
    localparam int IDX_W  = $clog2(MAX_SLICES);
    localparam int BASE_W = $clog2(KEY_W);
    localparam int END_W  = IDX_W + 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   shadow_q, shadow_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W:0]     rem_q, rem_d;
    logic               err_q, err_d;

    logic [END_W-1:0]   slice_end;
    logic [END_W-1:0]   key_slices;
    logic               cmd_legal;
    logic [KEY_W-1:0]   key_sel;
    logic [BASE_W-1:0]  slice_base;

    always_comb begin
        key_slices = '0;
        key_sel    = '0;
        case (cmdKey)
            3'd0: begin key_slices = END_W'(4);          key_sel = KEY_W'(privateKey); end
            3'd1: begin key_slices = END_W'(5);          key_sel = KEY_W'(q);          end
            3'd2: begin key_slices = END_W'(MAX_SLICES); key_sel = p;                  end
            3'd3: begin key_slices = END_W'(MAX_SLICES); key_sel = g;                  end
            3'd4: begin key_slices = END_W'(MAX_SLICES); key_sel = y;                  end
            default: begin key_slices = '0;              key_sel = '0;                 end
        endcase
    end

    // Range check in a wider sum so first+count cannot overflow past the key end.
    assign slice_end = END_W'(cmdFirst) + END_W'(cmdCount);
    assign cmd_legal = (cmdKey <= 3'd4) && (cmdCount != '0) && (slice_end <= key_slices);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmdValid) begin
                    if (cmd_legal) begin
                        shadow_d = key_sel;
                        idx_d    = cmdFirst;
                        rem_d    = cmdCount;
                        state_d  = ST_STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                // Abort drops the pending slice even if it is being accepted this cycle.
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (dataReady) begin
                    if (rem_q == (IDX_W+1)'(1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        rem_d = rem_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
        end
    end

    assign slice_base = BASE_W'(idx_q) * BASE_W'(SLICE_W);

    assign cmdReady  = (state_q == ST_IDLE);
    assign dataValid = (state_q == ST_STREAM);
    assign dataOut   = dataValid ? shadow_q[slice_base +: SLICE_W] : '0;
    assign dataSlice = idx_q;
    assign dataLast  = dataValid && (rem_q == (IDX_W+1)'(1));
    assign cmdError  = err_q;

endmodule

// File: tb/tb_key_slice_reader.sv
// Directed bench for key_slice_reader: inputs change and outputs are checked
// on the falling clock edge, away from the active rising edge.
module tb_key_slice_reader;

    logic           clock;
    logic           resetN;
    logic [127:0]   privateKey;
    logic [159:0]   q;
    logic [1023:0]  p, g, y;
    logic           cmdValid;
    logic           cmdReady;
    logic [2:0]     cmdKey;
    logic [4:0]     cmdFirst;
    logic [5:0]     cmdCount;
    logic           abort;
    logic [31:0]    dataOut;
    logic           dataValid;
    logic           dataReady;
    logic [4:0]     dataSlice;
    logic           dataLast;
    logic           cmdError;

    int nvec;
    int nbad;

    key_slice_reader dut (
        .clock      (clock),
        .resetN     (resetN),
        .privateKey (privateKey),
        .q          (q),
        .p          (p),
        .g          (g),
        .y          (y),
        .cmdValid   (cmdValid),
        .cmdReady   (cmdReady),
        .cmdKey     (cmdKey),
        .cmdFirst   (cmdFirst),
        .cmdCount   (cmdCount),
        .abort      (abort),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .dataReady  (dataReady),
        .dataSlice  (dataSlice),
        .dataLast   (dataLast),
        .cmdError   (cmdError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slice(input string tag, input logic [31:0] exp_data,
                             input logic [4:0] exp_idx, input logic exp_last);
        chk({tag, ".valid"}, 32'(dataValid), 32'd1);
        chk({tag, ".data"},  dataOut, exp_data);
        chk({tag, ".slice"}, 32'(dataSlice), 32'(exp_idx));
        chk({tag, ".last"},  32'(dataLast), 32'(exp_last));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(dataValid), 32'd0);
        chk({tag, ".ready"}, 32'(cmdReady), 32'd1);
    endtask

    task automatic send_cmd(input logic [2:0] k, input logic [4:0] f, input logic [5:0] c);
        cmdValid = 1'b1;
        cmdKey   = k;
        cmdFirst = f;
        cmdCount = c;
    endtask

    initial begin
        int  exp_idx;
        int  cyc;
        bit  done;

        nvec = 0;
        nbad = 0;
        resetN = 1'b0;
        cmdValid = 1'b0; cmdKey = '0; cmdFirst = '0; cmdCount = '0;
        abort = 1'b0; dataReady = 1'b1;
        privateKey = {32'h0BAD0003, 32'h0BAD0002, 32'h0BAD0001, 32'h0BAD0000};
        q = {32'hA0000004, 32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        p = '0;
        p[31:0]  = 32'hC5F4B81A;
        p[63:32] = 32'h00000001;
        for (int k = 0; k < 32; k++) begin
            g[k*32 +: 32] = 32'h66000000 + 32'(k);
            y[k*32 +: 32] = 32'h77000000 + 32'(k);
        end

        // Reset state
        @(negedge clock);
        chk("rst.valid", 32'(dataValid), 32'd0);
        chk("rst.ready", 32'(cmdReady), 32'd1);
        chk("rst.data",  dataOut, 32'd0);
        chk("rst.slice", 32'(dataSlice), 32'd0);
        chk("rst.last",  32'(dataLast), 32'd0);
        chk("rst.err",   32'(cmdError), 32'd0);
        resetN = 1'b1;

        // 1: p, two slices, latency 1
        @(negedge clock);
        send_cmd(3'd2, 5'd0, 6'd2);
        @(negedge clock);
        cmdValid = 1'b0;
        chk_slice("t1.s0", 32'hC5F4B81A, 5'd0, 1'b0);
        chk("t1.busy", 32'(cmdReady), 32'd0);
        @(negedge clock);
        chk_slice("t1.s1", 32'h00000001, 5'd1, 1'b1);
        @(negedge clock);
        chk_idle("t1.end");

        // 2: q upper slices, then an out-of-range count
        send_cmd(3'd1, 5'd3, 6'd2);
        @(negedge clock);
        cmdValid = 1'b0;
        chk_slice("t2.s3", 32'hA0000003, 5'd3, 1'b0);
        @(negedge clock);
        chk_slice("t2.s4", 32'hA0000004, 5'd4, 1'b1);
        @(negedge clock);
        chk_idle("t2.end");
        send_cmd(3'd1, 5'd3, 6'd3);
        @(negedge clock);
        cmdValid = 1'b0;
        chk("t2.err", 32'(cmdError), 32'd1);
        chk_idle("t2.errst");
        @(negedge clock);
        chk("t2.errclr", 32'(cmdError), 32'd0);
        chk_idle("t2.after");

        // 3: y full width with dataReady toggling
        send_cmd(3'd4, 5'd0, 6'd32);
        @(negedge clock);
        cmdValid = 1'b0;
        exp_idx = 0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 200) begin
            if (cyc != 0) @(negedge clock);
            chk_slice("t3.s", 32'h77000000 + 32'(exp_idx), 5'(exp_idx), exp_idx == 31);
            dataReady = cyc[0];
            if (dataReady) begin
                if (exp_idx == 31) done = 1'b1;
                else exp_idx++;
            end
            cyc++;
        end
        chk("t3.done", 32'(done), 32'd1);
        @(negedge clock);
        dataReady = 1'b1;
        chk_idle("t3.end");
        send_cmd(3'd5, 5'd0, 6'd1);
        @(negedge clock);
        cmdValid = 1'b0;
        chk("t3.badkey", 32'(cmdError), 32'd1);
        chk("t3.badkey.v", 32'(dataValid), 32'd0);
        @(negedge clock);
        send_cmd(3'd2, 5'd0, 6'd0);
        @(negedge clock);
        cmdValid = 1'b0;
        chk("t3.cnt0", 32'(cmdError), 32'd1);
        chk("t3.cnt0.v", 32'(dataValid), 32'd0);
        @(negedge clock);

        // 4: snapshot isolation from key-store writes
        send_cmd(3'd0, 5'd0, 6'd4);
        @(negedge clock);
        cmdValid = 1'b0;
        chk_slice("t4.s0", 32'h0BAD0000, 5'd0, 1'b0);
        @(negedge clock);
        privateKey = {32'hFEED0003, 32'hFEED0002, 32'hFEED0001, 32'hFEED0000};
        chk_slice("t4.s1", 32'h0BAD0001, 5'd1, 1'b0);
        @(negedge clock);
        chk_slice("t4.s2", 32'h0BAD0002, 5'd2, 1'b0);
        @(negedge clock);
        chk_slice("t4.s3", 32'h0BAD0003, 5'd3, 1'b1);
        @(negedge clock);
        chk_idle("t4.end");
        send_cmd(3'd0, 5'd0, 6'd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            cmdValid = 1'b0;
            chk_slice("t4.new", 32'hFEED0000 + 32'(k), 5'(k), k == 3);
        end
        @(negedge clock);

        // 5: abort on third slice, command held off then accepted
        send_cmd(3'd3, 5'd2, 6'd8);
        @(negedge clock);
        cmdValid = 1'b0;
        chk_slice("t5.s2", 32'h66000002, 5'd2, 1'b0);
        @(negedge clock);
        chk_slice("t5.s3", 32'h66000003, 5'd3, 1'b0);
        @(negedge clock);
        chk_slice("t5.s4", 32'h66000004, 5'd4, 1'b0);
        abort = 1'b1;
        send_cmd(3'd3, 5'd10, 6'd1);
        @(negedge clock);
        abort = 1'b0;
        chk_idle("t5.abort");
        chk("t5.abort.last", 32'(dataLast), 32'd0);
        @(negedge clock);
        cmdValid = 1'b0;
        chk_slice("t5.new", 32'h6600000A, 5'd10, 1'b1);
        @(negedge clock);
        chk_idle("t5.end");

        // 6: asynchronous reset mid-stream
        send_cmd(3'd4, 5'd5, 6'd10);
        @(negedge clock);
        cmdValid = 1'b0;
        chk_slice("t6.s5", 32'h77000005, 5'd5, 1'b0);
        #2 resetN = 1'b0;
        #1;
        chk("t6.rst.valid", 32'(dataValid), 32'd0);
        chk("t6.rst.data",  dataOut, 32'd0);
        chk("t6.rst.slice", 32'(dataSlice), 32'd0);
        chk("t6.rst.last",  32'(dataLast), 32'd0);
        chk("t6.rst.ready", 32'(cmdReady), 32'd1);
        chk("t6.rst.err",   32'(cmdError), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk_idle("t6.post");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
